// File: rtl/gamma_cfg_sched_pkg.sv
// Shared gamma configuration definitions: selector codes, selector width,
// scheduler state encoding and a counter-width helper.
package gamma_cfg_sched_pkg;

  localparam int GAMMA_SEL_W = 5;

  // Code 0 is the pass-through (no curve) selector; the others pick a LUT curve.
  localparam logic [GAMMA_SEL_W-1:0] GAMMA_SEL_PASS = 5'd0;
  localparam logic [GAMMA_SEL_W-1:0] GAMMA_SEL_SRGB = 5'd1;
  localparam logic [GAMMA_SEL_W-1:0] GAMMA_SEL_BT709 = 5'd2;
  localparam logic [GAMMA_SEL_W-1:0] GAMMA_SEL_G22 = 5'd3;
  localparam logic [GAMMA_SEL_W-1:0] GAMMA_SEL_G24 = 5'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gamma_cfg_sched_frame_edge_det.sv
// Polarity-corrects vsync and emits a one-cycle frame_start on its leading edge.
module gamma_cfg_sched_frame_edge_det #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic vsync,
  output logic frame_start
);

  logic vs_act;
  logic vs_prev;

  assign vs_act = vsync ^ ACTIVE_LOW;

  // History resets to the inactive level so a vsync already active at reset
  // release still counts as a frame start.
  always_ff @(posedge clock) begin
    if (reset) vs_prev <= 1'b0;
    else       vs_prev <= vs_act;
  end

  assign frame_start = vs_act & ~vs_prev;

endmodule

// File: rtl/gamma_cfg_sched.sv
// Applies gamma LUT selector changes only at frame starts, then holds each
// setting for HOLD_FRAMES frames; a cycle timeout stands in for missing vsync.
module gamma_cfg_sched
  import gamma_cfg_sched_pkg::*;
#(
  parameter int                   CFG_WIDTH        = GAMMA_SEL_W,
  parameter logic [CFG_WIDTH-1:0] RESET_CONFIG     = CFG_WIDTH'(GAMMA_SEL_PASS),
  parameter bit                   VSYNC_ACTIVE_LOW = 1'b1,
  parameter int                   HOLD_FRAMES      = 2,
  parameter int                   TIMEOUT_CYCLES   = 2000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 vsync,
  input  logic                 req_valid,
  input  logic [CFG_WIDTH-1:0] req_config,
  output logic                 req_ready,
  output logic [CFG_WIDTH-1:0] gamma_config,
  output logic                 cfg_ack,
  output logic                 busy,
  output logic                 timeout_flag
);

  localparam int TC_W = cnt_width(TIMEOUT_CYCLES);
  localparam int HC_W = cnt_width(HOLD_FRAMES + 1);
  localparam logic [TC_W-1:0] T_LAST = TC_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]           state;
  logic [CFG_WIDTH-1:0] pending;
  logic [TC_W-1:0]      tcount;
  logic [HC_W-1:0]      hcount;
  logic                 forced;
  logic                 frame_start;
  logic                 accept;

  gamma_cfg_sched_frame_edge_det #(
    .ACTIVE_LOW(VSYNC_ACTIVE_LOW)
  ) u_edge (
    .clock      (clock),
    .reset      (reset),
    .vsync      (vsync),
    .frame_start(frame_start)
  );

  // Handshake: a request transfers on any cycle where req_valid and req_ready
  // are both high; req_ready is a pure decode of the state register.
  assign req_ready = (state == ST_IDLE) || (state == ST_WAIT);
  assign busy      = (state != ST_IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      pending      <= RESET_CONFIG;
      tcount       <= '0;
      hcount       <= '0;
      forced       <= 1'b0;
      gamma_config <= RESET_CONFIG;
      cfg_ack      <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (req_config == gamma_config) begin
              cfg_ack <= 1'b1;
            end else begin
              pending <= req_config;
              tcount  <= '0;
              state   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (accept) pending <= req_config;
          if (frame_start) begin
            forced <= 1'b0;
            state  <= ST_APPLY;
          end else if (tcount == T_LAST) begin
            forced <= 1'b1;
            state  <= ST_APPLY;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        ST_APPLY: begin
          gamma_config <= pending;
          cfg_ack      <= 1'b1;
          timeout_flag <= forced;
          hcount       <= HC_W'(HOLD_FRAMES);
          tcount       <= '0;
          state        <= (HOLD_FRAMES == 0) ? ST_IDLE : ST_HOLD;
        end
        default: begin
          // A timeout counts as a frame so the hold cannot stall without vsync.
          if (frame_start || tcount == T_LAST) begin
            tcount <= '0;
            if (hcount <= HC_W'(1)) begin
              hcount <= '0;
              state  <= ST_IDLE;
            end else begin
              hcount <= hcount - 1'b1;
            end
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_cfg_sched.sv
// Directed bench for gamma_cfg_sched with TIMEOUT_CYCLES=50, HOLD_FRAMES=2,
// active-low vsync.
module tb_gamma_cfg_sched;

  logic       clock;
  logic       reset;
  logic       vsync;
  logic       req_valid;
  logic [4:0] req_config;
  logic       req_ready;
  logic [4:0] gamma_config;
  logic       cfg_ack;
  logic       busy;
  logic       timeout_flag;

  int checks;
  int failures;

  gamma_cfg_sched #(
    .CFG_WIDTH       (5),
    .RESET_CONFIG    (5'd0),
    .VSYNC_ACTIVE_LOW(1'b1),
    .HOLD_FRAMES     (2),
    .TIMEOUT_CYCLES  (50)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .vsync       (vsync),
    .req_valid   (req_valid),
    .req_config  (req_config),
    .req_ready   (req_ready),
    .gamma_config(gamma_config),
    .cfg_ack     (cfg_ack),
    .busy        (busy),
    .timeout_flag(timeout_flag)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_req(input logic [4:0] cfg);
    req_valid  = 1'b1;
    req_config = cfg;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic frame_pulse();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    vsync      = 1'b1;
    req_valid  = 1'b0;
    req_config = 5'd0;
    ticks(2);

    check("rst_gamma", gamma_config, 5'd0);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ack", cfg_ack, 1'b0);
    check("rst_tflag", timeout_flag, 1'b0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", req_ready, 1'b1);

    // Normal apply
    send_req(5'd3);
    check("norm_busy", busy, 1'b1);
    check("norm_wait_ready", req_ready, 1'b1);
    ticks(20);
    check("norm_gamma_pre", gamma_config, 5'd0);
    vsync = 1'b0;
    tick();
    check("norm_apply_ack", cfg_ack, 1'b0);
    check("norm_apply_ready", req_ready, 1'b0);
    check("norm_apply_gamma", gamma_config, 5'd0);
    tick();
    check("norm_gamma", gamma_config, 5'd3);
    check("norm_ack", cfg_ack, 1'b1);
    check("norm_tflag", timeout_flag, 1'b0);
    vsync = 1'b1;
    tick();
    check("norm_ack_drop", cfg_ack, 1'b0);
    check("norm_hold_ready0", req_ready, 1'b0);
    frame_pulse();
    check("norm_hold_ready1", req_ready, 1'b0);
    frame_pulse();
    check("norm_hold_done_ready", req_ready, 1'b1);
    check("norm_hold_done_busy", busy, 1'b0);

    // Last request wins
    send_req(5'd5);
    send_req(5'd6);
    tick();
    check("lw_ack_wait", cfg_ack, 1'b0);
    vsync = 1'b0;
    tick();
    check("lw_ack_apply", cfg_ack, 1'b0);
    tick();
    check("lw_gamma", gamma_config, 5'd6);
    check("lw_ack", cfg_ack, 1'b1);
    vsync = 1'b1;
    tick();
    check("lw_ack_once", cfg_ack, 1'b0);
    frame_pulse();
    frame_pulse();
    check("lw_idle", busy, 1'b0);

    // Accept in the frame_start cycle is the one applied
    send_req(5'd9);
    req_valid  = 1'b1;
    req_config = 5'd12;
    vsync      = 1'b0;
    tick();
    req_valid  = 1'b0;
    tick();
    check("fs_accept_gamma", gamma_config, 5'd12);
    check("fs_accept_ack", cfg_ack, 1'b1);
    vsync = 1'b1;
    tick();
    frame_pulse();
    frame_pulse();
    check("fs_idle", busy, 1'b0);

    // Same value request
    send_req(5'd12);
    check("same_ack", cfg_ack, 1'b1);
    check("same_busy", busy, 1'b0);
    check("same_gamma", gamma_config, 5'd12);
    tick();
    check("same_ack_drop", cfg_ack, 1'b0);

    // Timeout with no vsync
    send_req(5'd7);
    ticks(49);
    check("to_not_yet_busy", busy, 1'b1);
    check("to_not_yet_ready", req_ready, 1'b1);
    tick();
    check("to_apply_gamma", gamma_config, 5'd12);
    check("to_apply_ready", req_ready, 1'b0);
    tick();
    check("to_gamma", gamma_config, 5'd7);
    check("to_ack", cfg_ack, 1'b1);
    check("to_tflag", timeout_flag, 1'b1);
    ticks(99);
    check("to_hold_busy", busy, 1'b1);
    tick();
    check("to_hold_exit", busy, 1'b0);
    check("to_tflag_sticky", timeout_flag, 1'b1);

    // vsync-triggered apply clears the sticky flag
    send_req(5'd2);
    ticks(3);
    vsync = 1'b0;
    tick();
    tick();
    check("vs_clear_gamma", gamma_config, 5'd2);
    check("vs_clear_tflag", timeout_flag, 1'b0);
    vsync = 1'b1;
    tick();
    frame_pulse();
    frame_pulse();
    check("vs_clear_idle", busy, 1'b0);

    // Reset while waiting with a pending request
    send_req(5'd4);
    check("rw_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    check("rw_gamma", gamma_config, 5'd0);
    check("rw_ack", cfg_ack, 1'b0);
    check("rw_busy_clr", busy, 1'b0);
    reset = 1'b0;
    tick();
    vsync = 1'b0;
    tick();
    check("rw_vs_ack0", cfg_ack, 1'b0);
    tick();
    check("rw_vs_ack1", cfg_ack, 1'b0);
    check("rw_vs_gamma", gamma_config, 5'd0);
    check("rw_vs_busy", busy, 1'b0);
    vsync = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
